nabp_shift_sequencer: RTL and testbench
=======================================

# nabp_shift_sequencer

Per-line sequencer that drives the projection-mapping stage and the processing-element (PE) shift chain in the backprojection datapath. On a kick from state control it produces the mapper's start pulse, one shift enable per line element (stalled by line-buffer availability), a RAM-latency-aligned PE shift enable, and a completion pulse. It sits between state control (upstream) and the mapper / line-buffer RAM / PE chain (downstream), and is the sole source of the mapper's `sh_kick`, `sh_shift_en` and `sh_done`.

## Interface

Parameters:
- `LINE_SIZE`, 256, number of elements shifted per line (≥2)
- `RAM_LATENCY`, 1, read latency of the line-buffer RAM in cycles (0–4)
- `CNT_W`, clog2(LINE_SIZE), width of the element counter

Ports:
- `clk` in 1: clock
- `reset_n` in 1: synchronous, active-low reset
- `sc_kick` in 1: start one line; sampled only while `sh_ready`=1
- `lb_valid` in 1: line buffer can supply an element this cycle
- `sh_ready` out 1: idle, will accept `sc_kick`
- `sh_kick` out 1: one-cycle mapper start pulse
- `sh_shift_en` out 1: mapper advance / element request this cycle
- `sh_done` out 1: one-cycle line-complete pulse to mapper and state control
- `sh_cnt` out CNT_W: index of element requested by the current `sh_shift_en`
- `pe_shift_en` out 1: PE chain shift, `sh_shift_en` delayed by `RAM_LATENCY`

## Operation

- States: READY, KICK, SHIFT, DRAIN, DONE. Outputs are Moore decodes of state plus registered pipeline.
- READY: `sh_ready`=1. If `sc_kick`=1 → KICK; else hold.
- KICK: `sh_kick`=1 for exactly this cycle; `sh_cnt` cleared to 0; → SHIFT unconditionally.
- SHIFT: `sh_shift_en` = `lb_valid` (combinational, same cycle). On each cycle with `sh_shift_en`=1: if `sh_cnt`=LINE_SIZE−1 → DRAIN (or DONE if RAM_LATENCY=0), else `sh_cnt`+1. `lb_valid`=0 holds state and counter (stall, unbounded).
- DRAIN: lasts exactly RAM_LATENCY cycles (internal down-counter); `sh_shift_en`=0; → DONE.
- DONE: `sh_done`=1 for exactly this cycle; → READY.
- `pe_shift_en`: RAM_LATENCY-deep shift register of `sh_shift_en`, cleared on reset; RAM_LATENCY=0 means direct wire. By construction the pipeline is empty on entry to DONE.
- `sc_kick` outside READY is ignored (not queued), including in DONE.
- `sh_cnt` holds its last value in DRAIN/DONE/READY until the next KICK.
- Exactly LINE_SIZE `sh_shift_en` pulses and LINE_SIZE `pe_shift_en` pulses per line.
- Invalid state encoding → READY on next edge.

## Timing

- Reset (`reset_n`=0 at edge): state READY; `sh_ready`=1; `sh_kick`, `sh_shift_en`, `sh_done`, `pe_shift_en`=0; `sh_cnt`=0; pipeline and drain counter cleared. Reset mid-line aborts immediately; no `sh_done` is emitted.
- Edge 0 samples `sc_kick`=1 in READY. Cycle after edge 0: KICK (`sh_kick`=1, `sh_ready`=0). Mapper enters mapping at edge 1; first `sh_shift_en` possible in the cycle after edge 1.
- With `lb_valid` always 1: SHIFT occupies LINE_SIZE cycles, DRAIN RAM_LATENCY cycles, DONE 1 cycle; `sh_ready` returns LINE_SIZE+RAM_LATENCY+2 cycles after the KICK cycle began.
- Each stall cycle adds one cycle to the total; `pe_shift_en` reproduces the same gaps RAM_LATENCY cycles later.
- `sh_done` never coincides with `sh_shift_en` or `pe_shift_en`.

## Test plan

- Reset: hold `reset_n`=0 for 2 cycles with `sc_kick`=1 → all outputs at reset values, `sh_ready`=1, no `sh_kick`.
- Nominal, LINE_SIZE=8, RAM_LATENCY=1, `lb_valid`=1: kick at edge 0 → `sh_kick` in cycle 1; `sh_shift_en` in cycles 2–9 with `sh_cnt` 0..7; `pe_shift_en` in cycles 3–10; `sh_done` in cycle 11; `sh_ready`=1 in cycle 12.
- Stall: as nominal but `lb_valid`=0 in cycles 4–6 → `sh_cnt` holds 2 during stall, `sh_shift_en` gaps in cycles 4–6, `pe_shift_en` gaps in cycles 5–7, `sh_done` in cycle 14, still 8 pulses of each enable.
- Ignored kick: assert `sc_kick` in cycles 5 and 11 (SHIFT, DONE) → no effect; exactly one `sh_kick` per line; a new kick in cycle 12 starts a fresh line with `sh_cnt` from 0.
- Mid-line reset: `reset_n`=0 at edge with `sh_cnt`=5 → next cycle READY, `pe_shift_en`=0, no `sh_done`; subsequent kick runs a full 8-element line.
- RAM_LATENCY=0, LINE_SIZE=4: `pe_shift_en` identical to `sh_shift_en` (cycles 2–5), `sh_done` in cycle 6, no DRAIN state visited.

Source files
------------

// File: rtl/nabp_shift_sequencer.sv
// -----------------------------------------------------------------------------
// nabp_shift_sequencer
//
// Per-line sequencer for the backprojection datapath. A kick from state
// control starts one line. The line produces:
//   - a mapper start pulse,
//   - one shift enable per line element, stalled while the line buffer is empty,
//   - a PE-chain shift enable aligned to the line-buffer RAM read latency,
//   - a completion pulse.
//
// Ports
//   clk          in   clock
//   reset_n      in   synchronous, active-low reset
//   sc_kick      in   start one line (sampled only while sh_ready=1)
//   lb_valid     in   line buffer can supply an element this cycle
//   sh_ready     out  idle, will accept sc_kick
//   sh_kick      out  one-cycle mapper start pulse
//   sh_shift_en  out  mapper advance / element request this cycle
//   sh_done      out  one-cycle line-complete pulse
//   sh_cnt       out  index of the element requested by sh_shift_en
//   pe_shift_en  out  sh_shift_en delayed by RAM_LATENCY cycles
// -----------------------------------------------------------------------------
module nabp_shift_sequencer #(
    parameter int LINE_SIZE   = 256,
    parameter int RAM_LATENCY = 1,
    parameter int CNT_W       = $clog2(LINE_SIZE)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sc_kick,
    input  logic             lb_valid,
    output logic             sh_ready,
    output logic             sh_kick,
    output logic             sh_shift_en,
    output logic             sh_done,
    output logic [CNT_W-1:0] sh_cnt,
    output logic             pe_shift_en
);

    // The drain counter holds values up to RAM_LATENCY-1, and RAM_LATENCY is at most 4.
    localparam int DRAIN_W = 3;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_SIZE - 1);

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_KICK  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        sh_ready    = 1'b0;
        sh_kick     = 1'b0;
        sh_shift_en = 1'b0;
        sh_done     = 1'b0;

        case (state_q)
            ST_READY: begin
                sh_ready = 1'b1;
                if (sc_kick) begin
                    state_d = ST_KICK;
                    cnt_d   = '0;
                end
            end
            ST_KICK: begin
                sh_kick = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // An empty line buffer stalls the line, with no limit on the stall length.
                sh_shift_en = lb_valid;
                if (lb_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        if (RAM_LATENCY == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            // Wait here until the last request has left the RAM pipeline.
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_W'(RAM_LATENCY - 1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                sh_done = 1'b1;
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign sh_cnt = cnt_q;

    // The PE shift enable trails the element request by the RAM read latency.
    generate
        if (RAM_LATENCY == 0) begin : g_no_pipe
            assign pe_shift_en = sh_shift_en;
        end else begin : g_pipe
            logic [RAM_LATENCY-1:0] pipe_q;

            // NOTE: the alignment pipeline is reset with the FSM. A reset in the
            // middle of a line therefore leaves no stale PE shifts in flight.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= (pipe_q << 1) | RAM_LATENCY'(sh_shift_en);
                end
            end

            assign pe_shift_en = pipe_q[RAM_LATENCY-1];
        end
    endgenerate

endmodule

// File: tb/tb_nabp_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nabp_shift_sequencer
//
// Three sequencer instances are exercised:
//   A: LINE_SIZE=8, RAM_LATENCY=1
//   B: LINE_SIZE=4, RAM_LATENCY=0
//   C: LINE_SIZE=8, RAM_LATENCY=3
//
// The expected per-cycle output traces are derived from the event rules:
//   - A kick accepted while idle puts sh_kick in the next cycle.
//   - Valid cycles after the kick cycle become element requests, up to the line size.
//   - PE shifts are the requests delayed by the RAM latency.
//   - Done comes latency+1 cycles after the last request.
//
// Cycle c is the period ending at clock edge c.
// -----------------------------------------------------------------------------
module tb_nabp_shift_sequencer;

    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] kick_v;
    logic [2:0] valid_v;
    logic [2:0] ready_w, skick_w, shen_w, done_w, pe_w;
    logic [2:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] cnt_c;

    always #5 clk = ~clk;

    nabp_shift_sequencer #(.LINE_SIZE(8), .RAM_LATENCY(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .sc_kick(kick_v[0]), .lb_valid(valid_v[0]),
        .sh_ready(ready_w[0]), .sh_kick(skick_w[0]), .sh_shift_en(shen_w[0]),
        .sh_done(done_w[0]), .sh_cnt(cnt_a), .pe_shift_en(pe_w[0])
    );

    nabp_shift_sequencer #(.LINE_SIZE(4), .RAM_LATENCY(0)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .sc_kick(kick_v[1]), .lb_valid(valid_v[1]),
        .sh_ready(ready_w[1]), .sh_kick(skick_w[1]), .sh_shift_en(shen_w[1]),
        .sh_done(done_w[1]), .sh_cnt(cnt_b), .pe_shift_en(pe_w[1])
    );

    nabp_shift_sequencer #(.LINE_SIZE(8), .RAM_LATENCY(3)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .sc_kick(kick_v[2]), .lb_valid(valid_v[2]),
        .sh_ready(ready_w[2]), .sh_kick(skick_w[2]), .sh_shift_en(shen_w[2]),
        .sh_done(done_w[2]), .sh_cnt(cnt_c), .pe_shift_en(pe_w[2])
    );

    int line_of[3];
    int lat_of[3];
    int last_cnt[3];
    int checks;
    int failures;

    int n_cycles;
    bit stim_kick[MAXC];
    bit stim_valid[MAXC];
    bit exp_ready[MAXC];
    bit exp_kick[MAXC];
    bit exp_sh[MAXC];
    bit exp_done[MAXC];
    bit exp_pe[MAXC];
    int exp_cnt[MAXC];

    function automatic int cnt_of(input int idx);
        case (idx)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            stim_kick[c]  = 1'b0;
            stim_valid[c] = 1'b0;
        end
    endtask

    // Build the expected traces from the line-level rules.
    task automatic build_model(input int idx);
        int line_len;
        int lat;
        int free_from;
        int k;
        int n;
        int t;
        int done_c;
        int prev;
        line_len  = line_of[idx];
        lat       = lat_of[idx];
        free_from = 0;
        for (int c = 0; c < MAXC; c++) begin
            exp_ready[c] = 1'b1;
            exp_kick[c]  = 1'b0;
            exp_sh[c]    = 1'b0;
            exp_done[c]  = 1'b0;
            exp_pe[c]    = 1'b0;
            exp_cnt[c]   = -1;
        end
        for (int c = 0; c < n_cycles; c++) begin
            if (c >= free_from && stim_kick[c]) begin
                k            = c + 1;
                exp_kick[k]  = 1'b1;
                exp_ready[k] = 1'b0;
                exp_cnt[k]   = 0;
                n            = 0;
                t            = k + 1;
                while (n < line_len && t < MAXC - 8) begin
                    exp_ready[t] = 1'b0;
                    exp_cnt[t]   = n;
                    if (stim_valid[t]) begin
                        exp_sh[t]       = 1'b1;
                        exp_pe[t + lat] = 1'b1;
                        n++;
                    end
                    t++;
                end
                done_c = t + lat;
                for (int x = t; x <= done_c; x++) exp_ready[x] = 1'b0;
                exp_done[done_c] = 1'b1;
                free_from        = done_c + 1;
            end
        end
        prev = last_cnt[idx];
        for (int c = 0; c < n_cycles; c++) begin
            if (exp_cnt[c] < 0) exp_cnt[c] = prev;
            prev = exp_cnt[c];
        end
        last_cnt[idx] = prev;
    endtask

    // Drive the stimulus table into one instance and compare every cycle.
    task automatic run_scenario(input int idx, input string name);
        build_model(idx);
        for (int c = 0; c < n_cycles; c++) begin
            kick_v       = '0;
            valid_v      = '0;
            kick_v[idx]  = stim_kick[c];
            valid_v[idx] = stim_valid[c];
            @(negedge clk);
            checks++;
            if (ready_w[idx] !== exp_ready[c]) begin
                failures++;
                $display("FAIL %s sh_ready cyc=%0d got=%b exp=%b", name, c, ready_w[idx], exp_ready[c]);
            end
            checks++;
            if (skick_w[idx] !== exp_kick[c]) begin
                failures++;
                $display("FAIL %s sh_kick cyc=%0d got=%b exp=%b", name, c, skick_w[idx], exp_kick[c]);
            end
            checks++;
            if (shen_w[idx] !== exp_sh[c]) begin
                failures++;
                $display("FAIL %s sh_shift_en cyc=%0d got=%b exp=%b", name, c, shen_w[idx], exp_sh[c]);
            end
            checks++;
            if (done_w[idx] !== exp_done[c]) begin
                failures++;
                $display("FAIL %s sh_done cyc=%0d got=%b exp=%b", name, c, done_w[idx], exp_done[c]);
            end
            checks++;
            if (pe_w[idx] !== exp_pe[c]) begin
                failures++;
                $display("FAIL %s pe_shift_en cyc=%0d got=%b exp=%b", name, c, pe_w[idx], exp_pe[c]);
            end
            checks++;
            if (cnt_of(idx) !== exp_cnt[c]) begin
                failures++;
                $display("FAIL %s sh_cnt cyc=%0d got=%0d exp=%0d", name, c, cnt_of(idx), exp_cnt[c]);
            end
            step();
        end
        kick_v  = '0;
        valid_v = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        kick_v  = '1;
        valid_v = '1;
        step();
        step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ready_w[i] !== 1'b1 || skick_w[i] !== 1'b0 || shen_w[i] !== 1'b0 ||
                done_w[i] !== 1'b0 || pe_w[i] !== 1'b0 || cnt_of(i) !== 0) begin
                failures++;
                $display("FAIL reset dut%0d got rdy=%b kick=%b sh=%b done=%b pe=%b cnt=%0d exp 1 0 0 0 0 0",
                         i, ready_w[i], skick_w[i], shen_w[i], done_w[i], pe_w[i], cnt_of(i));
            end
        end
        step();
        reset_n = 1'b1;
        kick_v  = '0;
        valid_v = '0;
        step();
        for (int i = 0; i < 3; i++) last_cnt[i] = 0;
    endtask

    task automatic test_nominal();
        clear_stim();
        n_cycles     = 16;
        stim_kick[0] = 1'b1;
        for (int c = 0; c < n_cycles; c++) stim_valid[c] = 1'b1;
        run_scenario(0, "nominal");
    endtask

    task automatic test_stall();
        clear_stim();
        n_cycles     = 20;
        stim_kick[0] = 1'b1;
        for (int c = 0; c < n_cycles; c++) stim_valid[c] = !(c >= 4 && c <= 6);
        run_scenario(0, "stall");
    endtask

    task automatic test_ignored_kick();
        clear_stim();
        n_cycles      = 30;
        stim_kick[0]  = 1'b1;
        stim_kick[5]  = 1'b1;
        stim_kick[11] = 1'b1;
        stim_kick[12] = 1'b1;
        for (int c = 0; c < n_cycles; c++) stim_valid[c] = 1'b1;
        run_scenario(0, "ignored_kick");
    endtask

    task automatic test_lat0();
        clear_stim();
        n_cycles     = 10;
        stim_kick[0] = 1'b1;
        for (int c = 0; c < n_cycles; c++) stim_valid[c] = 1'b1;
        run_scenario(1, "lat0");
    endtask

    task automatic test_back_to_back();
        clear_stim();
        n_cycles = 60;
        for (int c = 0; c < n_cycles; c++) begin
            stim_kick[c]  = (c < 40);
            stim_valid[c] = 1'b1;
        end
        run_scenario(2, "back_to_back");
    endtask

    task automatic test_random();
        string nm;
        for (int idx = 0; idx < 3; idx++) begin
            clear_stim();
            n_cycles = 200;
            for (int c = 0; c < n_cycles; c++) begin
                if (c < 140) begin
                    stim_kick[c]  = ($urandom_range(0, 3) == 0);
                    stim_valid[c] = ($urandom_range(0, 3) != 0);
                end else begin
                    stim_kick[c]  = 1'b0;
                    stim_valid[c] = 1'b1;
                end
            end
            nm = $sformatf("random_dut%0d", idx);
            run_scenario(idx, nm);
        end
    endtask

    task automatic test_mid_reset();
        kick_v     = '0;
        valid_v    = '0;
        kick_v[0]  = 1'b1;
        valid_v[0] = 1'b1;
        step();                           // now in cycle 1
        kick_v[0] = 1'b0;
        for (int i = 0; i < 6; i++) step(); // now in cycle 7
        @(negedge clk);
        checks++;
        if (cnt_a !== 3'd5 || shen_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre cnt=%0d sh=%b exp cnt=5 sh=1", cnt_a, shen_w[0]);
        end
        reset_n = 1'b0;
        step();                           // cycle 8
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_w[0] !== 1'b1 || pe_w[0] !== 1'b0 || done_w[0] !== 1'b0 || cnt_a !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset_post rdy=%b pe=%b done=%b cnt=%0d exp 1 0 0 0",
                     ready_w[0], pe_w[0], done_w[0], cnt_a);
        end
        valid_v = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (done_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset_idle step=%0d done=%b rdy=%b exp 0 1", i, done_w[0], ready_w[0]);
            end
        end
        step();
        for (int i = 0; i < 3; i++) last_cnt[i] = 0;
        clear_stim();
        n_cycles     = 16;
        stim_kick[0] = 1'b1;
        for (int c = 0; c < n_cycles; c++) stim_valid[c] = 1'b1;
        run_scenario(0, "post_reset_line");
    endtask

    initial begin
        line_of  = '{8, 4, 8};
        lat_of   = '{1, 0, 3};
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        kick_v   = '0;
        valid_v  = '0;
        test_reset();
        test_nominal();
        test_stall();
        test_ignored_kick();
        test_lat0();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
